snake_len_counter: RTL and testbench

Game-state length tracker for the IR-controlled snake game. Counts food events into a packed-BCD snake length and keeps a session best score. Sits directly upstream of the seven-segment display stage: its `snake_length` output drives the display's 8-bit length input, two nibbles = two decimal digits. Driven by the snake game logic (eat/collision) and the IR key decoder (start).

---
 rtl/snake_pkg.sv | 18 +
 rtl/snake_len_counter_bcd_inc8.sv | 33 +++
 rtl/snake_len_counter.sv | 122 ++++++++++++
 tb/tb_snake_len_counter.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared types and constants for the snake game length tracker.
package snake_pkg;

  // Game phase, encoded as it appears on the game_state output.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_OVER = 2'd2
  } state_t;

  // Width of one packed-BCD decimal digit.
  localparam int BCD_DIGIT_W = 4;

  // Default starting and saturation lengths, packed BCD.
  localparam logic [7:0] DEF_INIT_LEN = 8'h03;
  localparam logic [7:0] DEF_MAX_LEN  = 8'h99;

endpackage

// File: rtl/snake_len_counter_bcd_inc8.sv
// Combinational packed-BCD +1 on two digits; carry-out marks 99 -> 00 wrap.
module bcd_inc8
  import snake_pkg::*;
(
  input  logic [2*BCD_DIGIT_W-1:0] i_val,
  output logic [2*BCD_DIGIT_W-1:0] o_sum,
  output logic                     o_carry
);

  logic [BCD_DIGIT_W-1:0] w_ones;
  logic [BCD_DIGIT_W-1:0] w_tens;

  assign w_ones = i_val[BCD_DIGIT_W-1:0];
  assign w_tens = i_val[2*BCD_DIGIT_W-1:BCD_DIGIT_W];

  // Ripple the increment through ones then tens, wrapping each digit at 9.
  always_comb begin
    o_sum   = i_val;
    o_carry = 1'b0;
    if (w_ones == 4'd9) begin
      o_sum[BCD_DIGIT_W-1:0] = 4'd0;
      if (w_tens == 4'd9) begin
        o_sum[2*BCD_DIGIT_W-1:BCD_DIGIT_W] = 4'd0;
        o_carry = 1'b1;
      end else begin
        o_sum[2*BCD_DIGIT_W-1:BCD_DIGIT_W] = w_tens + 4'd1;
      end
    end else begin
      o_sum[BCD_DIGIT_W-1:0] = w_ones + 4'd1;
    end
  end

endmodule

// File: rtl/snake_len_counter.sv
// Snake length tracker: counts food events into a packed-BCD length,
// tracks the session best score and the IDLE/PLAY/OVER game phase.
module snake_len_counter
  import snake_pkg::*;
#(
  parameter logic [7:0] INIT_LEN = DEF_INIT_LEN,
  parameter logic [7:0] MAX_LEN  = DEF_MAX_LEN
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       eat,
  input  logic       hit,
  output logic [7:0] snake_length,
  output logic [7:0] best_length,
  output logic [1:0] game_state,
  output logic       length_full
);

  logic   r_start_d;
  logic   r_eat_d;
  logic   r_hit_d;
  logic   w_start_rise;
  logic   w_eat_rise;
  logic   w_hit_rise;

  state_t     r_state;
  state_t     w_state_next;
  logic [7:0] r_len;
  logic [7:0] w_len_next;
  logic [7:0] r_best;
  logic [7:0] w_best_next;
  logic       r_full;
  logic       w_full_next;

  logic [7:0] w_inc_sum;
  logic       w_inc_carry;
  logic       w_inc_ok;

  // Delayed copies of the level inputs for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_start_d <= 1'b0;
      r_eat_d   <= 1'b0;
      r_hit_d   <= 1'b0;
    end else begin
      r_start_d <= start;
      r_eat_d   <= eat;
      r_hit_d   <= hit;
    end
  end

  assign w_start_rise = start & ~r_start_d;
  assign w_eat_rise   = eat   & ~r_eat_d;
  assign w_hit_rise   = hit   & ~r_hit_d;

  bcd_inc8 u_inc (
    .i_val   (r_len),
    .o_sum   (w_inc_sum),
    .o_carry (w_inc_carry)
  );

  // Saturate at MAX_LEN; the carry guard also blocks any 99 -> 00 wrap.
  assign w_inc_ok = (r_len != MAX_LEN) && !w_inc_carry;

  // Game state, length, best score and full flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_len   <= 8'h00;
      r_best  <= 8'h00;
      r_full  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_len   <= w_len_next;
      r_best  <= w_best_next;
      r_full  <= w_full_next;
    end
  end

  // Next-state logic: hit outranks eat in PLAY, best is captured on entry to OVER.
  always_comb begin
    w_state_next = r_state;
    w_len_next   = r_len;
    w_best_next  = r_best;
    case (r_state)
      ST_IDLE: begin
        if (w_start_rise) begin
          w_state_next = ST_PLAY;
          w_len_next   = INIT_LEN;
        end
      end
      ST_PLAY: begin
        if (w_hit_rise) begin
          w_state_next = ST_OVER;
          if (r_len > r_best) begin
            w_best_next = r_len;
          end
        end else if (w_eat_rise && w_inc_ok) begin
          w_len_next = w_inc_sum;
        end
      end
      ST_OVER: begin
        if (w_start_rise) begin
          w_state_next = ST_PLAY;
          w_len_next   = INIT_LEN;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_len_next   = 8'h00;
      end
    endcase
    w_full_next = (w_state_next != ST_IDLE) && (w_len_next == MAX_LEN);
  end

  assign snake_length = r_len;
  assign best_length  = r_best;
  assign game_state   = r_state;
  assign length_full  = r_full;

endmodule

// File: tb/tb_snake_len_counter.sv
// Self-checking bench for snake_len_counter: directed steps plus random
// traffic compared against a decimal-integer model of the game rules.
module tb_snake_len_counter;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       eat;
  logic       hit;
  logic [7:0] snake_length;
  logic [7:0] best_length;
  logic [1:0] game_state;
  logic       length_full;

  int checks   = 0;
  int failures = 0;

  // Reference model: length and best as plain decimal integers.
  int m_state;  // 0 idle, 1 play, 2 over
  int m_len;
  int m_best;
  bit m_ps, m_pe, m_ph;

  localparam int INIT_DEC = 3;
  localparam int MAX_DEC  = 99;

  snake_len_counter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .eat          (eat),
    .hit          (hit),
    .snake_length (snake_length),
    .best_length  (best_length),
    .game_state   (game_state),
    .length_full  (length_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] to_bcd(input int n);
    return 8'(((n / 10) * 16) + (n % 10));
  endfunction

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check8({tag, ".len"},   snake_length, to_bcd(m_len));
    check8({tag, ".best"},  best_length,  to_bcd(m_best));
    check8({tag, ".state"}, {6'd0, game_state}, 8'(m_state));
    check8({tag, ".full"},  {7'd0, length_full},
           {7'd0, (m_state != 0) && (m_len == MAX_DEC)});
  endtask

  task automatic model_reset();
    m_state = 0; m_len = 0; m_best = 0;
    m_ps = 0; m_pe = 0; m_ph = 0;
  endtask

  task automatic model_update(input bit s, input bit e, input bit h);
    bit sr, er, hr;
    sr = s & ~m_ps; er = e & ~m_pe; hr = h & ~m_ph;
    case (m_state)
      0: if (sr) begin m_state = 1; m_len = INIT_DEC; end
      1: begin
        if (hr) begin
          m_state = 2;
          if (m_len > m_best) m_best = m_len;
        end else if (er && m_len < MAX_DEC) begin
          m_len = m_len + 1;
        end
      end
      default: if (sr) begin m_state = 1; m_len = INIT_DEC; end
    endcase
    m_ps = s; m_pe = e; m_ph = h;
  endtask

  task automatic step(input bit s, input bit e, input bit h);
    @(negedge clk);
    start = s; eat = e; hit = h;
    @(posedge clk);
    model_update(s, e, h);
    #1;
    check_all("step");
    $display("step start=%0b eat=%0b hit=%0b -> state=%0d len=%h best=%h full=%0b",
             s, e, h, game_state, snake_length, best_length, length_full);
  endtask

  task automatic eats(input int n);
    repeat (n) begin
      step(0, 1, 0);
      step(0, 0, 0);
    end
  endtask

  task automatic async_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check8({tag, ".rst_len"},   snake_length, 8'h00);
    check8({tag, ".rst_best"},  best_length,  8'h00);
    check8({tag, ".rst_state"}, {6'd0, game_state}, 8'h00);
    check8({tag, ".rst_full"},  {7'd0, length_full}, 8'h00);
    $display("reset %s -> state=%0d len=%h best=%h", tag, game_state, snake_length, best_length);
    @(negedge clk);
    start = 0; eat = 0; hit = 0;
    rst_n = 1'b1;
  endtask

  initial begin
    start = 0; eat = 0; hit = 0;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Start from IDLE.
    step(1, 0, 0);
    step(0, 0, 0);
    check8("start.len", snake_length, 8'h03);
    check8("start.state", {6'd0, game_state}, 8'h01);
    check8("start.full", {7'd0, length_full}, 8'h00);

    // Grow to 12, hit, best captures 12.
    eats(9);
    check8("grow12.len", snake_length, 8'h12);
    step(0, 0, 1);
    step(0, 0, 0);
    check8("over12.best", best_length, 8'h12);
    check8("over12.state", {6'd0, game_state}, 8'h02);

    // eat and hit ignored in OVER.
    eats(2);
    step(0, 0, 1);
    check8("over.hold", snake_length, 8'h12);

    // Restart, reach 07, hit: best kept at 12.
    step(1, 0, 0);
    step(0, 0, 0);
    eats(4);
    step(0, 0, 1);
    step(0, 0, 0);
    check8("over07.len", snake_length, 8'h07);
    check8("over07.best", best_length, 8'h12);

    // Restart, reach 08, two long eat pulses -> 09, 10.
    step(1, 0, 0);
    step(0, 0, 0);
    eats(5);
    repeat (5) step(0, 1, 0);
    step(0, 0, 0);
    check8("held1.len", snake_length, 8'h09);
    repeat (5) step(0, 1, 0);
    step(0, 0, 0);
    check8("held2.len", snake_length, 8'h10);

    // Climb to 99 and push past it: saturates, full set.
    eats(89);
    check8("max.len", snake_length, 8'h99);
    check8("max.full", {7'd0, length_full}, 8'h01);
    eats(3);
    check8("sat.len", snake_length, 8'h99);
    check8("sat.full", {7'd0, length_full}, 8'h01);
    step(0, 0, 1);
    step(0, 0, 0);
    check8("over99.best", best_length, 8'h99);

    // Restart clears full; eat and hit together at 05: hit wins.
    step(1, 0, 0);
    check8("restart.full", {7'd0, length_full}, 8'h00);
    step(0, 0, 0);
    eats(2);
    step(0, 1, 1);
    step(0, 0, 0);
    check8("tie.len", snake_length, 8'h05);
    check8("tie.state", {6'd0, game_state}, 8'h02);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 24) == 0);
    end

    // Mid-game reset at 20, then eat while IDLE.
    async_reset("pre20");
    step(1, 0, 0);
    step(0, 0, 0);
    eats(17);
    check8("grow20.len", snake_length, 8'h20);
    async_reset("mid20");
    eats(2);
    step(0, 0, 1);
    check8("idle.len", snake_length, 8'h00);
    check8("idle.state", {6'd0, game_state}, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
